mem_port_arbiter: RTL
=====================

# mem_port_arbiter

- Shares one single-ported, variable-latency memory between the CPU fetch stage (IF) and the memory stage (MEM).
- Arbitrates the two requesters, sequences each memory transaction, and returns read data with a one-cycle ready pulse.
- Data (MEM) accesses have priority, and a starvation counter guarantees fetch progress.
- Sits between the pipeline's fetch/memory stages and the shared memory, replacing the separate instruction and data memories.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive DM grants allowed while IF waits (≥1)
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch request (level), held with `if_addr` until `if_ready`
- `if_addr` in AW: fetch address
- `if_flush` in 1: drop the in-flight or granted fetch result (pipeline flush)
- `if_ready` out 1: one-cycle pulse, `if_rdata` valid
- `if_rdata` out DW: fetched word (registered)
- `dm_req` in 1: data request (level), held with `dm_we`/`dm_addr`/`dm_wdata` until `dm_ready`
- `dm_we` in 1: 1 = write, 0 = read
- `dm_addr` in AW: data address
- `dm_wdata` in DW: write data
- `dm_ready` out 1: one-cycle completion pulse (reads and writes)
- `dm_rdata` out DW: read data (registered, unchanged on writes)
- `mem_en` out 1: one-cycle transaction strobe
- `mem_we` out 1: write qualifier (valid with `mem_en`)
- `mem_addr` out AW: address (held from strobe until ack)
- `mem_wdata` out DW: write data (held from strobe until ack)
- `mem_ack` in 1: completion; `mem_rdata` valid in the same cycle
- `mem_rdata` in DW: memory read data

## Operation
- **FSM states**
  - IDLE: arbitrate.
  - ISSUE: `mem_en`=1 for exactly one cycle.
  - WAIT: hold address/data until `mem_ack`.
- **IDLE transitions**
  - No request: stay.
  - Otherwise: latch owner (IF/DM), address, write data and `we`; go to ISSUE.
- **ISSUE → WAIT** unconditionally. `mem_ack` in the ISSUE cycle is illegal and ignored.
- **WAIT transitions**
  - On `mem_ack`: register `mem_rdata` into the owner's rdata (reads only), pulse the owner's ready next cycle, return to IDLE.
  - No ack: stay indefinitely (no timeout).
- **Arbitration** (IDLE only)
  - DM wins when both request, unless `starve_cnt == STARVE_MAX`, in which case IF wins.
  - `starve_cnt` increments on each DM grant while `if_req`=1 and saturates at STARVE_MAX.
  - `starve_cnt` clears on any IF grant, or when `if_req`=0 at an arbitration decision.
- **Flush**
  - `if_flush` high during ISSUE or WAIT of an IF transaction, or in the ack cycle, sets `drop`.
  - At completion with `drop` set: no `if_ready`, `if_rdata` unchanged, `drop` clears. The memory transaction still completes.
  - `if_flush` in IDLE, or during a DM transaction, has no effect.
- **Requester rule**
  - In the cycle its ready is high, a requester either drops req or presents the next access.
  - A req sampled in that cycle is treated as a new request.
- `mem_ack` in IDLE is ignored.
- **Reset** (`rst_n`=0, any state, including mid-transaction)
  - State → IDLE. `starve_cnt`, `drop` and all outputs → 0, including `if_rdata`, `dm_rdata`, `mem_addr`, `mem_wdata`.
  - The in-flight transaction is abandoned. The memory shares the same reset.

## Timing
- Request sampled at edge E0 (IDLE).
  - `mem_en` high in cycle E0–E1 (ISSUE).
  - Earliest `mem_ack` in cycle E1–E2.
  - Ready high in cycle E2–E3.
- Minimum request-to-ready latency is 3 cycles; the memory adds N wait cycles for N+3.
- Back-to-back throughput: one transaction per 3 + N cycles. The next arbitration is at the edge ending the ready cycle.
- All outputs are registered. No combinational path exists from any input to any output.
- `mem_addr`, `mem_we` and `mem_wdata` are stable from ISSUE through the ack cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WAIT of a DM write to 0x10 → all outputs 0 next cycle. After release with no requests, `mem_en` stays 0.
- **Single IF read**
  - Stimulus: `if_addr`=0x40, memory acks one cycle after `mem_en` with 0xDEADBEEF.
  - Required: `mem_en` one cycle after req, `mem_addr`=0x40, `if_ready` pulses one cycle after ack, `if_rdata`=0xDEADBEEF.
- **Simultaneous requests:** `if_req` and `dm_req` (read 0x80) both high → DM granted first. IF is issued at the next IDLE; `dm_ready` precedes `if_ready`.
- **Starvation:** `if_req` held with `dm_req` continuously high, STARVE_MAX=4 → exactly 4 DM transactions, then 1 IF, then DM resumes.
- **Flush**
  - Stimulus: IF read, `if_flush` pulsed during WAIT, ack after 3 wait cycles.
  - Required: no `if_ready`, `if_rdata` unchanged. A following IF request to 0x44 completes normally.
- **DM write with wait states:** `dm_we`=1, `dm_addr`=0x20, `dm_wdata`=0x12345678, ack delayed 5 cycles → `mem_we`=1, address/data stable for all 6 post-strobe cycles, `dm_ready` one pulse, `dm_rdata` unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency memory between the fetch stage
// (IF) and the memory stage (DM). Requests are arbitrated in IDLE. Each
// granted access is then sequenced as ISSUE (a one-cycle mem_en strobe)
// followed by WAIT (address and data held until mem_ack). Completion is
// reported to the owner as a one-cycle ready pulse together with registered
// read data. DM has priority. A starvation counter forces an IF grant after
// STARVE_MAX consecutive DM grants while IF is waiting.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   if_req / if_addr     fetch request (level) and address, held until if_ready
//   if_flush             discard the result of the in-flight / granted fetch
//   if_ready / if_rdata  fetch completion pulse and fetched word
//   dm_req / dm_we       data request (level) and write qualifier
//   dm_addr / dm_wdata   data address and write data, held until dm_ready
//   dm_ready / dm_rdata  data completion pulse and read data (kept on writes)
//   mem_en / mem_we      one-cycle transaction strobe and write qualifier
//   mem_addr / mem_wdata address and write data, held from strobe to ack
//   mem_ack / mem_rdata  memory completion and read data (same cycle)
// All outputs are driven directly from registers.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIMIT = SCW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state,    w_state_next;
  logic            r_owner_dm, w_owner_dm_next;   // 1: DM owns the transaction
  logic [SCW-1:0]  r_starve,   w_starve_next;
  logic            r_drop,     w_drop_next;       // fetch result to be discarded
  logic            r_mem_en,   w_mem_en_next;
  logic            r_mem_we,   w_mem_we_next;
  logic [AW-1:0]   r_mem_addr, w_mem_addr_next;
  logic [DW-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic            r_if_ready, w_if_ready_next;
  logic [DW-1:0]   r_if_rdata, w_if_rdata_next;
  logic            r_dm_ready, w_dm_ready_next;
  logic [DW-1:0]   r_dm_rdata, w_dm_rdata_next;
  logic            w_grant_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner_dm  <= 1'b0;
      r_starve    <= '0;
      r_drop      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_ready  <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner_dm  <= w_owner_dm_next;
      r_starve    <= w_starve_next;
      r_drop      <= w_drop_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_if_ready  <= w_if_ready_next;
      r_if_rdata  <= w_if_rdata_next;
      r_dm_ready  <= w_dm_ready_next;
      r_dm_rdata  <= w_dm_rdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_owner_dm_next  = r_owner_dm;
    w_starve_next    = r_starve;
    w_drop_next      = r_drop;
    w_mem_en_next    = 1'b0;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_if_ready_next  = 1'b0;
    w_if_rdata_next  = r_if_rdata;
    w_dm_ready_next  = 1'b0;
    w_dm_rdata_next  = r_dm_rdata;
    w_grant_if       = 1'b0;

    case (r_state)
      S_IDLE: begin
        // IF only wins a contested slot once it has been passed over
        // STARVE_MAX times in a row.
        w_grant_if = if_req && (!dm_req || (r_starve == STARVE_LIMIT));

        if (!if_req || w_grant_if) begin
          w_starve_next = '0;
        end else if (dm_req && (r_starve != STARVE_LIMIT)) begin
          w_starve_next = r_starve + 1'b1;
        end

        if (if_req || dm_req) begin
          w_state_next     = S_ISSUE;
          w_mem_en_next    = 1'b1;
          w_owner_dm_next  = !w_grant_if;
          w_mem_addr_next  = w_grant_if ? if_addr : dm_addr;
          w_mem_we_next    = w_grant_if ? 1'b0 : dm_we;
          w_mem_wdata_next = w_grant_if ? '0 : dm_wdata;
          w_drop_next      = 1'b0;
        end
      end

      S_ISSUE: begin
        // An ack in this cycle is outside the memory protocol and is ignored.
        w_state_next = S_WAIT;
        if (!r_owner_dm && if_flush) begin
          w_drop_next = 1'b1;
        end
      end

      S_WAIT: begin
        if (mem_ack) begin
          w_state_next = S_IDLE;
          w_drop_next  = 1'b0;
          if (r_owner_dm) begin
            w_dm_ready_next = 1'b1;
            if (!r_mem_we) begin
              w_dm_rdata_next = mem_rdata;
            end
          end else if (!(r_drop || if_flush)) begin
            // A flush arriving in the ack cycle itself still cancels delivery.
            w_if_ready_next = 1'b1;
            w_if_rdata_next = mem_rdata;
          end
        end else if (!r_owner_dm && if_flush) begin
          w_drop_next = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = r_if_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_ready  = r_dm_ready;
  assign dm_rdata  = r_dm_rdata;

endmodule
